// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder LED controller.
package rotary_pkg;

  // Display modes selected by the two-bit mode input.
  typedef enum logic [1:0] {
    MODE_DOT     = 2'd0,
    MODE_BAR     = 2'd1,
    MODE_BAR_SAT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  // Quadrature contact states as seen on {b, a}.
  localparam logic [1:0] QUAD_00 = 2'b00;
  localparam logic [1:0] QUAD_01 = 2'b01;
  localparam logic [1:0] QUAD_10 = 2'b10;
  localparam logic [1:0] QUAD_11 = 2'b11;

endpackage

// File: rtl/rotary_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw contact.
// The output flips only after DEBOUNCE_CYCLES consecutive synchronised samples
// that all differ from the current output; any agreeing sample restarts the run.
module rotary_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  output logic db_out
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: shift the synchroniser and count disagreeing samples.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = {CNT_W{1'b0}};
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = {CNT_W{1'b0}};
      end else begin
        db_d  = db_q;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      db_d  = db_q;
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State registers; reset discards any partial debounce run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_out = db_q;

endmodule

// File: rtl/rotary_led_ctrl.sv
// Rotary encoder to LED bar/dot controller: debounced quadrature decoding,
// position counter with wrap/saturate/hold modes and a registered LED pattern.
module rotary_led_ctrl
  import rotary_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int POS_W           = $clog2(NUM_LEDS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rotary_a,
  input  logic                rotary_b,
  input  logic                rotary_press,
  input  logic                invert,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [POS_W-1:0]    position,
  output logic                step_valid,
  output logic                step_dir
);

  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    POS_ZERO = {POS_W{1'b0}};
  localparam logic [NUM_LEDS-1:0] PAT_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  // DOT lights only the current LED; bar modes light everything up to it.
  // (one_hot << 1) - 1 gives all ones when the top LED is selected.
  function automatic logic [NUM_LEDS-1:0] gen_pattern(input logic [POS_W-1:0] pos,
                                                      input mode_e          m);
    logic [NUM_LEDS-1:0] one_hot;
    one_hot      = {NUM_LEDS{1'b0}};
    one_hot[pos] = 1'b1;
    case (m)
      MODE_DOT:     gen_pattern = one_hot;
      MODE_BAR:     gen_pattern = {one_hot[NUM_LEDS-2:0], 1'b0} - PAT_ONE;
      MODE_BAR_SAT: gen_pattern = {one_hot[NUM_LEDS-2:0], 1'b0} - PAT_ONE;
      default:      gen_pattern = one_hot;
    endcase
  endfunction

  logic a_db_s, b_db_s, press_db_s;
  mode_e mode_s, eff_mode_s;
  logic step_fire_s, press_rise_s;

  logic                q1_q, q1_d;
  logic                q2_q, q2_d;
  logic                q1_prev_q, q1_prev_d;
  logic                press_prev_q, press_prev_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                step_valid_q, step_valid_d;
  logic                step_dir_q, step_dir_d;
  logic [NUM_LEDS-1:0] pattern_q, pattern_d;
  mode_e               hold_src_q, hold_src_d;

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (rotary_a),
    .db_out (a_db_s)
  );

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (rotary_b),
    .db_out (b_db_s)
  );

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_press (
    .clock  (clock),
    .reset_n(reset_n),
    .raw_in (rotary_press),
    .db_out (press_db_s)
  );

  assign mode_s = mode_e'(mode);

  // Quadrature filter: 00/11 drive q1, 01/10 drive q2; q2 at q1's rise gives direction.
  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    case ({b_db_s, a_db_s})
      QUAD_00: q1_d = 1'b0;
      QUAD_11: q1_d = 1'b1;
      QUAD_01: q2_d = 1'b0;
      QUAD_10: q2_d = 1'b1;
      default: begin
        q1_d = q1_q;
        q2_d = q2_q;
      end
    endcase
  end

  // Edge detection on q1 and the debounced press, plus the step report registers.
  always_comb begin
    q1_prev_d    = q1_q;
    press_prev_d = press_db_s;
    step_fire_s  = q1_q & ~q1_prev_q;
    press_rise_s = press_db_s & ~press_prev_q;
    step_valid_d = step_fire_s;
    if (step_fire_s) begin
      step_dir_d = q2_q;
    end else begin
      step_dir_d = step_dir_q;
    end
  end

  // Position counter: press wins over a step; HOLD freezes, BAR_SAT clamps, others wrap.
  always_comb begin
    pos_d = pos_q;
    if (press_rise_s) begin
      pos_d = POS_ZERO;
    end else if (step_fire_s) begin
      case (mode_s)
        MODE_HOLD: pos_d = pos_q;
        MODE_BAR_SAT: begin
          if (q2_q) begin
            pos_d = (pos_q == POS_MAX) ? pos_q : pos_q + POS_W'(1);
          end else begin
            pos_d = (pos_q == POS_ZERO) ? pos_q : pos_q - POS_W'(1);
          end
        end
        default: begin
          if (q2_q) begin
            pos_d = (pos_q == POS_MAX) ? POS_ZERO : pos_q + POS_W'(1);
          end else begin
            pos_d = (pos_q == POS_ZERO) ? POS_MAX : pos_q - POS_W'(1);
          end
        end
      endcase
    end else begin
      pos_d = pos_q;
    end
  end

  // Pattern generation; HOLD keeps displaying in the last non-HOLD mode.
  always_comb begin
    hold_src_d = hold_src_q;
    eff_mode_s = mode_s;
    if (mode_s == MODE_HOLD) begin
      eff_mode_s = hold_src_q;
      hold_src_d = hold_src_q;
    end else begin
      eff_mode_s = mode_s;
      hold_src_d = mode_s;
    end
    pattern_d = gen_pattern(pos_q, eff_mode_s);
  end

  // Controller state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1_q         <= 1'b0;
      q2_q         <= 1'b0;
      q1_prev_q    <= 1'b0;
      press_prev_q <= 1'b0;
      pos_q        <= POS_ZERO;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      pattern_q    <= PAT_ONE;
      hold_src_q   <= MODE_DOT;
    end else begin
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      q1_prev_q    <= q1_prev_d;
      press_prev_q <= press_prev_d;
      pos_q        <= pos_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      pattern_q    <= pattern_d;
      hold_src_q   <= hold_src_d;
    end
  end

  assign led_out    = pattern_q ^ {NUM_LEDS{invert}};
  assign position   = pos_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;

endmodule

// File: tb/tb_rotary_led_ctrl.sv
// Self-checking bench for rotary_led_ctrl: a behavioural reference model is
// compared every cycle, and directed scenarios pin the model with literals.
module tb_rotary_led_ctrl;

  localparam int N   = 8;
  localparam int DEB = 4;

  logic         clock;
  logic         reset_n;
  logic         rotary_a, rotary_b, rotary_press, invert;
  logic [1:0]   mode;
  logic [N-1:0] led_out;
  logic [2:0]   position;
  logic         step_valid, step_dir;

  int tests;
  int fails;
  int pulses;

  rotary_led_ctrl #(.NUM_LEDS(N), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rotary_a    (rotary_a),
    .rotary_b    (rotary_b),
    .rotary_press(rotary_press),
    .invert      (invert),
    .mode        (mode),
    .led_out     (led_out),
    .position    (position),
    .step_valid  (step_valid),
    .step_dir    (step_dir)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural reference model ----------------
  // A debounced input takes a new value once the last DEB synchronised
  // samples all agree on it; a step happens when the contacts reach 11
  // and the direction is whichever of 10/01 was seen last.
  logic [DEB-1:0] m_hist [3];
  logic [2:0]     m_s1, m_s2, m_db;
  logic           m_q1, m_q2, m_q1p, m_pp, m_sv, m_sd;
  int             m_pos;
  logic [1:0]     m_src;
  logic [N-1:0]   m_pat;

  function automatic logic [N-1:0] ref_pattern(input int pos, input logic [1:0] md);
    int v;
    if (md == 2'd0) v = 1 << pos;
    else            v = (1 << (pos + 1)) - 1;
    return v[N-1:0];
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    logic [DEB-1:0] h;
    logic [2:0]     db_n;
    logic           q1_n, q2_n, fire, prise;
    int             pos_n;
    logic [1:0]     eff;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_s1 = 3'b000; m_s2 = 3'b000; m_db = 3'b000;
      m_q1 = 1'b0; m_q2 = 1'b0; m_q1p = 1'b0; m_pp = 1'b0;
      m_sv = 1'b0; m_sd = 1'b0; m_pos = 0; m_src = 2'd0;
      m_pat = 8'h01;
    end else begin
      for (int i = 0; i < 3; i++) begin
        h = {m_hist[i][DEB-2:0], m_s2[i]};
        m_hist[i] = h;
        if (&h)       db_n[i] = 1'b1;
        else if (~|h) db_n[i] = 1'b0;
        else          db_n[i] = m_db[i];
      end
      q1_n = (m_db[1:0] == 2'b00) ? 1'b0 : (m_db[1:0] == 2'b11) ? 1'b1 : m_q1;
      q2_n = (m_db[1:0] == 2'b01) ? 1'b0 : (m_db[1:0] == 2'b10) ? 1'b1 : m_q2;
      fire  = m_q1 & ~m_q1p;
      prise = m_db[2] & ~m_pp;
      pos_n = m_pos;
      if (prise) pos_n = 0;
      else if (fire) begin
        if (mode == 2'd2)      pos_n = m_q2 ? ((m_pos < N-1) ? m_pos + 1 : m_pos)
                                            : ((m_pos > 0) ? m_pos - 1 : m_pos);
        else if (mode != 2'd3) pos_n = m_q2 ? (m_pos + 1) % N : (m_pos + N - 1) % N;
      end
      eff   = (mode == 2'd3) ? m_src : mode;
      m_pat = ref_pattern(m_pos, (eff == 2'd0) ? 2'd0 : 2'd1);
      if (mode != 2'd3) m_src = mode;
      if (fire) m_sd = m_q2;
      m_sv  = fire;
      m_pos = pos_n;
      m_pp  = m_db[2];
      m_q1p = m_q1;
      m_q1  = q1_n;
      m_q2  = q2_n;
      m_db  = db_n;
      m_s2  = m_s1;
      m_s1  = {rotary_press, rotary_b, rotary_a};
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare against the model mid-cycle, then step past the edge.
  task automatic tick();
    @(negedge clock);
    chk("model_pos",  32'(position),   32'(m_pos));
    chk("model_sv",   32'(step_valid), 32'(m_sv));
    chk("model_sd",   32'(step_dir),   32'(m_sd));
    chk("model_led",  32'(led_out),    32'(m_pat ^ {N{invert}}));
    if (step_valid === 1'b1) pulses++;
    @(posedge clock);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic detent(input logic left);
    logic [1:0] seq [4];
    if (left) begin seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00; end
    else      begin seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00; end
    for (int k = 0; k < 4; k++) begin
      {rotary_b, rotary_a} = seq[k];
      ticks(6);
    end
  endtask

  int p0;

  initial begin
    tests = 0; fails = 0; pulses = 0;
    rotary_a = 1'b0; rotary_b = 1'b0; rotary_press = 1'b0;
    invert = 1'b0; mode = 2'd0; reset_n = 1'b0;
    #2;
    ticks(3);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_led", 32'(led_out), 32'h01);
    chk("rst_sv",  32'(step_valid), 32'd0);
    reset_n = 1'b1;
    ticks(4);

    // One left detent in DOT.
    p0 = pulses;
    detent(1'b1);
    ticks(4);
    chk("left1_pulses", 32'(pulses - p0), 32'd1);
    chk("left1_dir", 32'(step_dir), 32'd1);
    chk("left1_pos", 32'(position), 32'd1);
    chk("left1_led", 32'(led_out), 32'h02);

    // Walk to 7, then wrap left and right.
    for (int k = 0; k < 6; k++) detent(1'b1);
    ticks(2);
    chk("pos7", 32'(position), 32'd7);
    chk("pos7_led", 32'(led_out), 32'h80);
    detent(1'b1);
    ticks(2);
    chk("wrap_left_pos", 32'(position), 32'd0);
    chk("wrap_left_led", 32'(led_out), 32'h01);
    detent(1'b0);
    ticks(2);
    chk("wrap_right_pos", 32'(position), 32'd7);
    chk("wrap_right_led", 32'(led_out), 32'h80);
    chk("wrap_right_dir", 32'(step_dir), 32'd0);

    // BAR_SAT clamps at the top but still reports the step.
    mode = 2'd2;
    ticks(2);
    chk("barsat_led", 32'(led_out), 32'hFF);
    p0 = pulses;
    detent(1'b1);
    ticks(2);
    chk("sat_pos", 32'(position), 32'd7);
    chk("sat_led", 32'(led_out), 32'hFF);
    chk("sat_pulses", 32'(pulses - p0), 32'd1);

    // BAR wraps; bring position down to 3.
    mode = 2'd1;
    for (int k = 0; k < 4; k++) detent(1'b0);
    ticks(2);
    chk("bar3_pos", 32'(position), 32'd3);
    chk("bar3_led", 32'(led_out), 32'h0F);

    // Short glitch on a must be rejected.
    p0 = pulses;
    rotary_a = 1'b1;
    ticks(3);
    rotary_a = 1'b0;
    ticks(20);
    chk("glitch_pulses", 32'(pulses - p0), 32'd0);
    chk("glitch_pos", 32'(position), 32'd3);

    // DOT to 5, then a press coincident with a left step.
    mode = 2'd0;
    detent(1'b1);
    detent(1'b1);
    ticks(2);
    chk("pos5", 32'(position), 32'd5);
    chk("pos5_led", 32'(led_out), 32'h20);
    p0 = pulses;
    {rotary_b, rotary_a} = 2'b10; ticks(6);
    {rotary_b, rotary_a} = 2'b11; ticks(1);
    rotary_press = 1'b1;          ticks(5);
    {rotary_b, rotary_a} = 2'b01; ticks(6);
    rotary_press = 1'b0;
    {rotary_b, rotary_a} = 2'b00; ticks(10);
    chk("press_pos", 32'(position), 32'd0);
    chk("press_pulses", 32'(pulses - p0), 32'd1);
    chk("press_led", 32'(led_out), 32'h01);
    invert = 1'b1;
    #1;
    chk("invert_led", 32'(led_out), 32'hFE);
    ticks(2);
    invert = 1'b0;

    // HOLD keeps the BAR pattern and position while steps are still reported.
    mode = 2'd1;
    detent(1'b1);
    detent(1'b1);
    ticks(2);
    chk("bar2_led", 32'(led_out), 32'h07);
    mode = 2'd3;
    p0 = pulses;
    detent(1'b1);
    ticks(2);
    chk("hold_pos", 32'(position), 32'd2);
    chk("hold_led", 32'(led_out), 32'h07);
    chk("hold_dir", 32'(step_dir), 32'd1);
    chk("hold_pulses", 32'(pulses - p0), 32'd1);
    detent(1'b0);
    ticks(2);
    chk("hold_dir_r", 32'(step_dir), 32'd0);
    chk("hold_pos_r", 32'(position), 32'd2);

    // Reset in the middle of a detent, then finish the old sequence.
    mode = 2'd0;
    ticks(2);
    {rotary_b, rotary_a} = 2'b10; ticks(6);
    {rotary_b, rotary_a} = 2'b11; ticks(6);
    reset_n = 1'b0;
    #1;
    chk("midrst_pos", 32'(position), 32'd0);
    chk("midrst_sv",  32'(step_valid), 32'd0);
    chk("midrst_dir", 32'(step_dir), 32'd0);
    chk("midrst_led", 32'(led_out), 32'h01);
    {rotary_b, rotary_a} = 2'b01;
    ticks(2);
    reset_n = 1'b1;
    p0 = pulses;
    ticks(6);
    {rotary_b, rotary_a} = 2'b00;
    ticks(20);
    chk("midrst_pulses", 32'(pulses - p0), 32'd0);
    chk("midrst_pos2", 32'(position), 32'd0);

    // Randomised phase, checked cycle by cycle against the model.
    for (int it = 0; it < 400; it++) begin
      {rotary_b, rotary_a} = 2'($urandom_range(0, 3));
      rotary_press = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) invert = ~invert;
      ticks($urandom_range(1, 10));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
